// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch (IF) and
// data-memory (DM) requesters. A granted request is latched and driven to
// the memory for MEM_LAT cycles, the read word is captured into the owner's
// rdata register, and the owner gets a one-cycle acknowledge.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants under
// contention (last-grant register present). Without it DM always wins a
// contention and IF may starve.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              dm_stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Access counter start value: the counter runs MEM_LAT-1 down to 0.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_t              state_r;
  logic [3:0]          cnt_r;
  logic                owner_dm_r;   // 1: DM owns the current access, 0: IF
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   if_rdata_r;
  logic [DATA_W-1:0]   dm_rdata_r;
  logic                if_ack_r;
  logic                dm_ack_r;
  logic                mem_en_r;
  logic                mem_we_r;
  logic                grant_dm_s;
  logic                any_req_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic                last_dm_r;    // 1: DM was granted last, 0: IF

  // Remember the most recent winner so the other side wins the next contention
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_dm_r <= 1'b0;
    end else if ((state_r == IDLE) && any_req_s) begin
      last_dm_r <= grant_dm_s;
    end else begin
      last_dm_r <= last_dm_r;
    end
  end
`endif

  assign any_req_s = if_req_i | dm_req_i;

  // Pick the requester that wins if the arbiter samples requests this cycle
  always_comb begin
    grant_dm_s = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (if_req_i && dm_req_i) begin
      grant_dm_s = ~last_dm_r;
    end else begin
      grant_dm_s = dm_req_i;
    end
`else
    if (dm_req_i) begin
      grant_dm_s = 1'b1;
    end else begin
      grant_dm_s = 1'b0;
    end
`endif
  end

  // Transaction sequencer: latch the winner, run the fixed-latency access,
  // capture read data and pulse the owner's acknowledge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      owner_dm_r <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      if_rdata_r <= {DATA_W{1'b0}};
      dm_rdata_r <= {DATA_W{1'b0}};
      if_ack_r   <= 1'b0;
      dm_ack_r   <= 1'b0;
      mem_en_r   <= 1'b0;
      mem_we_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if_ack_r <= 1'b0;
          dm_ack_r <= 1'b0;
          if (any_req_s) begin
            owner_dm_r <= grant_dm_s;
            // Fetches are always reads and carry no write data
            we_r       <= grant_dm_s & dm_we_i;
            mem_we_r   <= grant_dm_s & dm_we_i;
            addr_r     <= grant_dm_s ? dm_addr_i : if_addr_i;
            wdata_r    <= grant_dm_s ? dm_wdata_i : {DATA_W{1'b0}};
            cnt_r      <= CNT_LOAD;
            mem_en_r   <= 1'b1;
            state_r    <= ACCESS;
          end else begin
            state_r    <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
            // Writes leave both rdata registers untouched
            if (!we_r && owner_dm_r) begin
              dm_rdata_r <= mem_rdata_i;
            end else if (!we_r && !owner_dm_r) begin
              if_rdata_r <= mem_rdata_i;
            end else begin
              dm_rdata_r <= dm_rdata_r;
            end
            if_ack_r <= ~owner_dm_r;
            dm_ack_r <= owner_dm_r;
            state_r  <= RESP;
          end
        end
        RESP: begin
          // Requests are not sampled here; the acknowledge lasts one cycle
          if_ack_r <= 1'b0;
          dm_ack_r <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= 4'd0;
          if_ack_r <= 1'b0;
          dm_ack_r <= 1'b0;
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign if_rdata_o  = if_rdata_r;
  assign dm_rdata_o  = dm_rdata_r;
  assign if_ack_o    = if_ack_r;
  assign dm_ack_o    = dm_ack_r;
  assign mem_en_o    = mem_en_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = addr_r;
  assign mem_wdata_o = wdata_r;

  // Stalls fall in the acknowledge cycle so the pipeline advances with the data
  assign if_stall_o  = if_req_i & ~if_ack_r;
  assign dm_stall_o  = dm_req_i & ~dm_ack_r;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported unified memory between the CPU's instruction-fetch requester and data-memory requester. Each winning request is sequenced through a fixed-latency access, the result is returned with a one-cycle acknowledge, and per-requester stall signals freeze the PC and pipeline while a request is outstanding. The block sits between the core (PC/IM path and DM path) and the shared memory macro.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory access cycles per transaction (legal range 1..15)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request; held high until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched word, valid while if_ack_o is high
- if_ack_o  out  1  one-cycle fetch completion pulse
- if_stall_o  out  1  if_req_i & ~if_ack_o
- dm_req_i  in  1  data request; held high until dm_ack_o
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_rdata_o  out  DATA_W  read data, valid while dm_ack_o is high
- dm_ack_o  out  1  one-cycle data completion pulse
- dm_stall_o  out  1  dm_req_i & ~dm_ack_o
- mem_en_o  out  1  memory access enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid in the last access cycle

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if no request, stay. Otherwise pick a winner, latch its addr/we/wdata and owner, load cnt = MEM_LAT-1, then go to ACCESS.
- A fetch is always a read; the latched we for IF is 0.
- ACCESS: mem_en_o=1; mem_addr_o/mem_wdata_o come from the latches; mem_we_o = latched we. Outputs stay stable for all MEM_LAT cycles.
  - While cnt≠0: decrement.
  - When cnt==0: on a read, capture mem_rdata_i into the owner's rdata register; go to RESP.
- RESP: assert the owner's ack for exactly one cycle; requests are not sampled; go to IDLE.
- A write leaves dm_rdata_o unchanged.
- rdata registers hold their value until the next read by the same owner.
- Arbitration on simultaneous if_req_i and dm_req_i: see Configuration. A single request is always granted.
- Requests change only when acknowledged; changes mid-transaction are ignored because the arbiter uses latched values.
- A requester still high in the cycle after its ack starts a new transaction.
- cnt is 4 bits; MEM_LAT=1 goes IDLE→ACCESS(1 cycle)→RESP.
- Reset mid-transaction:
  - FSM→IDLE, cnt=0.
  - mem_en_o, mem_we_o, both acks → 0.
  - Any in-flight access is abandoned; no ack is issued.
  - The requester re-issues after reset.

## Timing
- Reset values:
  - all outputs 0 (rdata registers, mem_addr_o, mem_wdata_o = 0)
  - FSM=IDLE
  - last-grant = IF
- Request seen in IDLE at edge T: ACCESS during cycles T+1..T+MEM_LAT; ack high during cycle T+MEM_LAT+1.
- Request-to-ack latency is MEM_LAT+1 cycles from the first IDLE sample. Minimum spacing between back-to-back grants is MEM_LAT+2 cycles.
- Stall outputs are combinational from req_i and the registered acks. The stall for a requester drops in its ack cycle.
- A losing requester's stall stays high through the winner's full transaction.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on contention, grant the requester not served last (last-grant register is updated on every grant). With IF and DM both continuously requesting, grants alternate.
- Not defined: fixed priority, DM wins every contention and IF can starve. The last-grant register is not implemented.

## Test plan
- Reset: drive rst_i=0 mid-ACCESS (MEM_LAT=2) → next cycle mem_en_o=0, acks 0, FSM IDLE; after release, a pending if_req_i is serviced fresh.
- Single fetch: if_req_i=1, if_addr_i=0x40, memory returns 0x2002000A → mem_en_o high 2 cycles with mem_addr_o=0x40, mem_we_o=0; if_ack_o high in cycle 3 with if_rdata_o=0x2002000A; if_stall_o high in cycles 0-2 only.
- Data write: dm_we_i=1, dm_addr_i=0x10, dm_wdata_i=0xDEADBEEF → mem_we_o=1 for 2 cycles with those values; dm_ack_o in cycle 3; dm_rdata_o unchanged.
- Contention, round-robin: both requests held from reset → grant order DM, IF, DM, IF; each ack 4 cycles apart.
- Contention, fixed priority (macro undefined): both held → DM acked every 4 cycles; if_ack_o never asserts; if_stall_o stays 1.
- MEM_LAT=1 read of 0x0C → ack in cycle 2; requester address changed during ACCESS does not alter mem_addr_o.
